// File: rtl/pwm_pkg.sv
// Shared PWM definitions: duty width of the triangle PWM core and the
// ramp sequencer state encoding (kept as named 2-bit constants so other
// PWM blocks can decode the same state values).
package pwm_pkg;

    localparam int PWM_WIDTH = 4;

    localparam logic [1:0] ENC_IDLE     = 2'd0;
    localparam logic [1:0] ENC_RAMP     = 2'd1;
    localparam logic [1:0] ENC_SHUTDOWN = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = ENC_IDLE,
        RAMP     = ENC_RAMP,
        SHUTDOWN = ENC_SHUTDOWN
    } pwm_ramp_state_t;

endpackage

// File: rtl/pwm_step_sat.sv
// Combinational saturating step: moves duty one step toward target and
// never passes it. Arithmetic is WIDTH+1 bits so neither the sum can wrap
// past 2^WIDTH-1 nor the difference past 0.
//   duty   : current applied duty
//   target : ramp target
//   step   : step size (caller guarantees non-zero)
//   nxt    : next duty
module pwm_step_sat #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] duty,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] nxt
);

    logic [WIDTH:0] up_sum;
    logic [WIDTH:0] dn_diff;

    assign up_sum  = {1'b0, duty} + {1'b0, step};
    assign dn_diff = {1'b0, duty} - {1'b0, step};

    always_comb begin
        nxt = duty;
        if (target > duty) begin
            nxt = (up_sum > {1'b0, target}) ? target : up_sum[WIDTH-1:0];
        end else if (target < duty) begin
            // MSB set means the subtraction borrowed below zero
            nxt = (dn_diff[WIDTH] || (dn_diff[WIDTH-1:0] < target)) ?
                  target : dn_diff[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle sequencer for the triangle PWM core. Accepts a target duty
// over valid/ready, then slews duty_out toward it by step once every
// TICKS_PER_STEP period ticks. kill forces duty 0 and parks in SHUTDOWN.
//   clk, rst_n   : clock, async active-low reset
//   period_tick  : PWM period boundary pulse
//   kill         : level, zero duty and block requests
//   req_valid/req_ready/req_duty/req_step : target request handshake
//   duty_out     : registered duty to the PWM core
//   busy         : state != IDLE
//   done         : one-cycle pulse per completed request
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int WIDTH          = PWM_WIDTH,
    parameter int TICKS_PER_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             period_tick,
    input  logic             kill,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_duty,
    input  logic [WIDTH-1:0] req_step,
    output logic [WIDTH-1:0] duty_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(TICKS_PER_STEP + 1);
    localparam logic [CW-1:0] TPS = CW'(TICKS_PER_STEP);

    pwm_ramp_state_t  state;
    logic [CW-1:0]    tick_cnt;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] stp;
    logic [WIDTH-1:0] step_eff;
    logic [WIDTH-1:0] duty_nxt;

    // Decoded from the state register only, so no input-to-output path.
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    assign step_eff = (req_step == '0) ? WIDTH'(1) : req_step;

    pwm_step_sat #(.WIDTH(WIDTH)) u_step (
        .duty   (duty_out),
        .target (tgt),
        .step   (stp),
        .nxt    (duty_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            duty_out <= '0;
            done     <= 1'b0;
            tick_cnt <= '0;
            tgt      <= '0;
            stp      <= '0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                state    <= SHUTDOWN;
                duty_out <= '0;
                tick_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid) begin
                            tgt      <= req_duty;
                            stp      <= step_eff;
                            tick_cnt <= '0;
                            if (req_duty == duty_out) done  <= 1'b1;
                            else                      state <= RAMP;
                        end
                    end
                    RAMP: begin
                        if (period_tick) begin
                            if (tick_cnt + 1'b1 == TPS) begin
                                tick_cnt <= '0;
                                duty_out <= duty_nxt;
                                if (duty_nxt == tgt) begin
                                    done  <= 1'b1;
                                    state <= IDLE;
                                end
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    SHUTDOWN: state <= IDLE;
                    default:  state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Duty-cycle sequencer that drives the 4-bit `PWM_in` of the comparator-less triangle PWM core. It accepts a target duty from a requester over a valid/ready handshake and slews the applied duty toward that target by a programmable step once per PWM period, so the output never jumps. A level-sensitive kill input forces zero duty immediately. Placed between the control/register logic and the PWM core.

## Interface
- `WIDTH`, 4: duty width; matches the PWM core input.
- `TICKS_PER_STEP`, 1: PWM periods per ramp step; ≥1.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `period_tick`  in  1  one-cycle pulse from the PWM core at each counter-direction reversal (period boundary).
- `kill`  in  1  level; forces duty to 0 and blocks requests while high.
- `req_valid`  in  1  new target offered.
- `req_ready`  out  1  target accepted when `req_valid && req_ready`.
- `req_duty`  in  WIDTH  target duty.
- `req_step`  in  WIDTH  step size; 0 is treated as 1.
- `duty_out`  out  WIDTH  registered duty to the PWM core `PWM_in`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when a request completes.

## Operation
- States: IDLE, RAMP, SHUTDOWN. Priority per edge: reset > kill > period_tick > handshake.
- Reset values: state IDLE, `duty_out`=0, `req_ready`=1, `busy`=0, `done`=0, tick counter 0, latched target/step 0.
- IDLE: `req_ready`=1; `period_tick` ignored. On accept: latch `req_duty`, latch step (0→1), clear tick counter.
  - Target == `duty_out`: stay IDLE, pulse `done` on the next edge.
  - Otherwise go to RAMP.
- RAMP: `req_ready`=0, `req_valid` ignored. Each `period_tick` increments the tick counter; when it reaches `TICKS_PER_STEP`, clear it and move `duty_out` toward the target by step.
  - Step arithmetic in WIDTH+1 bits, saturated at the target: up = min(duty+step, target); down = max(duty−step, target). No overshoot and no wrap past 0 or 2^WIDTH−1.
  - The edge that writes the target value also asserts `done` and returns to IDLE. `req_ready` is 1 in the following cycle.
- Direction is decided per step by comparing `duty_out` with the target, so both up-ramps and down-ramps are legal.
- `kill` high in any state: the next edge sets `duty_out`=0, clears the tick counter and enters SHUTDOWN. Any ramp in progress is aborted without `done`.
- SHUTDOWN: `req_ready`=0; ticks and requests ignored. Stays while `kill`=1. The first edge with `kill`=0 enters IDLE with `duty_out` still 0.
- `rst_n` asserted mid-ramp: all outputs take their reset values immediately (asynchronous). No `done` is issued.

## Timing
- All outputs are registered. `req_ready` and `busy` are decoded from registered state only and have no combinational path from the inputs.
- Accept to first step: the first `period_tick` strictly after the accept edge counts. A tick coincident with the accept edge is ignored.
- Step latency: `duty_out` updates on the same edge that samples the qualifying `period_tick`. The PWM core latches it at its next period end.
- Ramp length = ceil(|target − start| / step) × `TICKS_PER_STEP` ticks.
- `kill`→`duty_out`=0: one clock edge, independent of `period_tick`.
- `done` is high for exactly one cycle per completed request and never asserts in SHUTDOWN.

## Structure
- Shared package `pwm_pkg`:
  - `PWM_WIDTH` = 4
  - state enum `pwm_ramp_state_t` {IDLE, RAMP, SHUTDOWN}
  - 2-bit encoding constants, reusable by future PWM blocks.
- Sub-module `pwm_step_sat` (combinational): inputs current duty, target, step; output next duty, saturated as described.
- FSM, tick counter (width $clog2(TICKS_PER_STEP+1)) and handshake stay in `pwm_ramp_ctrl`.

## Test plan
- Reset mid-ramp: ramp 0→12 step 2; drop `rst_n` at duty 6 → `duty_out`=0, `req_ready`=1, `busy`=0 asynchronously, before the next clock edge. No `done`.
- Up-ramp 0→10, step 3, `TICKS_PER_STEP`=1 → `duty_out` 3, 6, 9, 10 on successive ticks. `done` coincides with 10. `req_ready` returns 1 on the next cycle. A tick coincident with the accept edge causes no change.
- Down-ramp 15→4, step 4 → 11, 7, 4, then `done`. Step 0 from 0→2 → 1, 2.
- `TICKS_PER_STEP`=3, ramp 0→2 step 1 → `duty_out` changes only on the 3rd and 6th ticks. A request with target equal to the current duty → `done` on the next edge, no duty change.
- `kill` at duty 6 during a ramp → next edge `duty_out`=0, state SHUTDOWN, ticks and `req_valid` ignored, no `done`. Release → IDLE with `req_ready`=1 and duty 0.
- Overflow guard: duty 14, target 15, step 15 → 15 (no wrap). Duty 1, target 0, step 15 → 0.
